// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the lap stopwatch.
//   sw_state_t  : control FSM states
//   digit_radix : radix of a digit from its position and the time format
//   BCD_W       : width of one BCD digit
package stopwatch_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      STOPPED     = 2'd0,
      RUNNING     = 2'd1,
      LAP         = 2'd2,
      LAP_STOPPED = 2'd3
   } sw_state_t;

   // In time format, odd digits from index 3 upward are tens of seconds/minutes.
   function automatic int digit_radix(input int index, input int time_fmt);
      if ((time_fmt != 0) && (index >= 3) && ((index % 2) == 1))
         return 6;
      return 10;
   endfunction

endpackage

// File: rtl/stopwatch_digit.sv
// One BCD digit counter of configurable radix.
// Ports:
//   CLK   : clock
//   CLR   : asynchronous active-low reset
//   inc   : advance by one this cycle
//   clear : synchronous clear to zero (dominates inc)
//   value : current digit value
//   carry : combinational, inc while at RADIX-1 (next digit advances same edge)
module stopwatch_digit
   import stopwatch_pkg::*;
#(
   parameter int RADIX = 10
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             inc,
   input  logic             clear,
   output logic [BCD_W-1:0] value,
   output logic             carry
);

   localparam logic [BCD_W-1:0] LAST = BCD_W'(RADIX - 1);

   assign carry = inc & (value == LAST);

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR)
         value <= '0;
      else if (clear)
         value <= '0;
      else if (inc)
         value <= carry ? '0 : value + 1'b1;
   end

endmodule

// File: rtl/lap_stopwatch.sv
// Synchronous BCD stopwatch with start/stop, lap hold and clear-when-stopped.
// Ports:
//   CLK        : clock
//   CLR        : asynchronous active-low reset
//   START      : start/stop button level
//   LAP        : lap/clear button level
//   num        : displayed BCD value, digit 0 in num[3:0]
//   running    : count is advancing
//   lap_active : display frozen on the lap register
//   overflow   : sticky, set when the whole count wraps
//
// state       | meaning
// ------------+-------------------------------------------
// STOPPED     | count held, display live; LAP clears
// RUNNING     | count advancing, display live
// LAP         | count advancing, display frozen
// LAP_STOPPED | count held, display frozen
module lap_stopwatch #(
   parameter int DIGITS   = 4,
   parameter int CLK_DIV  = 100000,
   parameter int TIME_FMT = 1
) (
   input  logic                                  CLK,
   input  logic                                  CLR,
   input  logic                                  START,
   input  logic                                  LAP,
   output logic [stopwatch_pkg::BCD_W*DIGITS-1:0] num,
   output logic                                  running,
   output logic                                  lap_active,
   output logic                                  overflow
);

   localparam int CNT_W = stopwatch_pkg::BCD_W * DIGITS;
   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

   stopwatch_pkg::sw_state_t state;

   logic             start_q, start_prev, lap_q, lap_prev;
   logic             start_press, lap_press;
   logic             clear_cnt, capture, tick;
   logic [PRE_W-1:0] pre;
   logic [DIGITS:0]  inc_chain;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] lap_reg;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         start_q    <= 1'b0;
         start_prev <= 1'b0;
         lap_q      <= 1'b0;
         lap_prev   <= 1'b0;
      end else begin
         start_q    <= START;
         start_prev <= start_q;
         lap_q      <= LAP;
         lap_prev   <= lap_q;
      end
   end

   // START wins a tie; the LAP press is simply dropped.
   assign start_press = start_q & ~start_prev;
   assign lap_press   = lap_q & ~lap_prev & ~start_press;

   assign clear_cnt = lap_press & (state == stopwatch_pkg::STOPPED);
   assign capture   = lap_press & (state == stopwatch_pkg::RUNNING);

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state      <= stopwatch_pkg::STOPPED;
         running    <= 1'b0;
         lap_active <= 1'b0;
      end else begin
         case (state)
            stopwatch_pkg::STOPPED:
               if (start_press) begin
                  state   <= stopwatch_pkg::RUNNING;
                  running <= 1'b1;
               end
            stopwatch_pkg::RUNNING:
               if (start_press) begin
                  state   <= stopwatch_pkg::STOPPED;
                  running <= 1'b0;
               end else if (lap_press) begin
                  state      <= stopwatch_pkg::LAP;
                  lap_active <= 1'b1;
               end
            stopwatch_pkg::LAP:
               if (start_press) begin
                  state   <= stopwatch_pkg::LAP_STOPPED;
                  running <= 1'b0;
               end else if (lap_press) begin
                  state      <= stopwatch_pkg::RUNNING;
                  lap_active <= 1'b0;
               end
            stopwatch_pkg::LAP_STOPPED:
               if (start_press) begin
                  state   <= stopwatch_pkg::LAP;
                  running <= 1'b1;
               end else if (lap_press) begin
                  state      <= stopwatch_pkg::STOPPED;
                  lap_active <= 1'b0;
               end
            default: begin
               state      <= stopwatch_pkg::STOPPED;
               running    <= 1'b0;
               lap_active <= 1'b0;
            end
         endcase
      end
   end

   // Enable is the registered running flag, so the edge that stops the
   // watch still applies a coincident tick. Stopping keeps the partial period.
   assign tick = running & (pre == PRE_LAST);

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR)
         pre <= '0;
      else if (clear_cnt)
         pre <= '0;
      else if (running)
         pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
   end

   assign inc_chain[0] = tick;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      stopwatch_digit #(
         .RADIX (stopwatch_pkg::digit_radix(i, TIME_FMT))
      ) u_digit (
         .CLK   (CLK),
         .CLR   (CLR),
         .inc   (inc_chain[i]),
         .clear (clear_cnt),
         .value (count[stopwatch_pkg::BCD_W*i +: stopwatch_pkg::BCD_W]),
         .carry (inc_chain[i+1])
      );
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         lap_reg  <= '0;
         overflow <= 1'b0;
      end else if (clear_cnt) begin
         lap_reg  <= '0;
         overflow <= 1'b0;
      end else begin
         if (capture)
            lap_reg <= count;
         if (inc_chain[DIGITS])
            overflow <= 1'b1;
      end
   end

   assign num = lap_active ? lap_reg : count;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch. dut1: 4 digits, divide 1, time format.
// dut2: 4 digits, divide 4, plain decimal. Inputs driven and outputs sampled
// on the falling edge.
module tb_lap_stopwatch;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        start1 = 1'b0, lap1 = 1'b0;
   logic        start2 = 1'b0, lap2 = 1'b0;
   logic [15:0] num1, num2;
   logic        running1, lap_active1, overflow1;
   logic        running2, lap_active2, overflow2;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   lap_stopwatch #(.DIGITS(4), .CLK_DIV(1), .TIME_FMT(1)) dut1 (
      .CLK(clk), .CLR(clr), .START(start1), .LAP(lap1),
      .num(num1), .running(running1), .lap_active(lap_active1), .overflow(overflow1)
   );

   lap_stopwatch #(.DIGITS(4), .CLK_DIV(4), .TIME_FMT(0)) dut2 (
      .CLK(clk), .CLR(clr), .START(start2), .LAP(lap2),
      .num(num2), .running(running2), .lap_active(lap_active2), .overflow(overflow2)
   );

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_start1();
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
   endtask

   task automatic press_lap1();
      lap1 = 1'b1;
      @(negedge clk);
      lap1 = 1'b0;
   endtask

   task automatic press_start2();
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
   endtask

   task automatic do_reset();
      clr = 1'b0;
      @(negedge clk);
      clr = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({num1, running1, lap_active1, overflow1} !== 19'h0) begin
         errors++;
         $display("FAIL reset_initial: num=%h run=%b lap=%b ovf=%b expected all 0",
                  num1, running1, lap_active1, overflow1);
      end
      @(negedge clk);
      clr = 1'b1;
      press_start1();
      wait_cyc(8);
      checks++;
      if (num1 !== 16'h0007 || running1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_prerun: num=%h run=%b expected 0007 1", num1, running1);
      end
      #2 clr = 1'b0;
      #1;
      checks++;
      if ({num1, running1, lap_active1, overflow1} !== 19'h0) begin
         errors++;
         $display("FAIL reset_async: num=%h run=%b lap=%b ovf=%b expected all 0",
                  num1, running1, lap_active1, overflow1);
      end
      @(negedge clk);
      clr = 1'b1;
   endtask

   task automatic test_count_overflow();
      do_reset();
      press_start1();
      wait_cyc(1);
      checks++;
      if (num1 !== 16'h0000 || running1 !== 1'b1) begin
         errors++;
         $display("FAIL start_latency: num=%h run=%b expected 0000 1", num1, running1);
      end
      wait_cyc(100);
      checks++;
      if (num1 !== 16'h0100) begin
         errors++;
         $display("FAIL count_100: num=%h expected 0100", num1);
      end
      wait_cyc(5899);
      checks++;
      if (num1 !== 16'h5999 || overflow1 !== 1'b0) begin
         errors++;
         $display("FAIL count_max: num=%h ovf=%b expected 5999 0", num1, overflow1);
      end
      wait_cyc(1);
      checks++;
      if (num1 !== 16'h0000 || overflow1 !== 1'b1) begin
         errors++;
         $display("FAIL count_wrap: num=%h ovf=%b expected 0000 1", num1, overflow1);
      end
      press_start1();
      wait_cyc(1);
      checks++;
      if (num1 !== 16'h0002 || running1 !== 1'b0 || overflow1 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: num=%h run=%b ovf=%b expected 0002 0 1",
                  num1, running1, overflow1);
      end
      press_lap1();
      wait_cyc(1);
      checks++;
      if (num1 !== 16'h0000 || overflow1 !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: num=%h ovf=%b expected 0000 0", num1, overflow1);
      end
   endtask

   task automatic test_lap_hold();
      int bad = 0;
      logic [15:0] bad_val = 16'h0;
      do_reset();
      press_start1();
      wait_cyc(1);
      wait_cyc(41);
      press_lap1();
      wait_cyc(1);
      checks++;
      if (num1 !== 16'h0042 || lap_active1 !== 1'b1 || running1 !== 1'b1) begin
         errors++;
         $display("FAIL lap_capture: num=%h lap=%b run=%b expected 0042 1 1",
                  num1, lap_active1, running1);
      end
      for (int k = 0; k < 47; k++) begin
         wait_cyc(1);
         if (num1 !== 16'h0042 && bad == 0) begin
            bad = 1;
            bad_val = num1;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL lap_freeze: num=%h expected 0042", bad_val);
      end
      press_lap1();
      wait_cyc(1);
      checks++;
      if (num1 !== 16'h0092 || lap_active1 !== 1'b0) begin
         errors++;
         $display("FAIL lap_release: num=%h lap=%b expected 0092 0", num1, lap_active1);
      end
   endtask

   task automatic test_stop_clear();
      int trans = 0;
      logic prev;
      do_reset();
      press_start1();
      wait_cyc(1);
      wait_cyc(315);
      press_start1();
      wait_cyc(1);
      checks++;
      if (num1 !== 16'h0317 || running1 !== 1'b0) begin
         errors++;
         $display("FAIL stop: num=%h run=%b expected 0317 0", num1, running1);
      end
      wait_cyc(5);
      checks++;
      if (num1 !== 16'h0317) begin
         errors++;
         $display("FAIL stop_hold: num=%h expected 0317", num1);
      end
      press_lap1();
      wait_cyc(1);
      checks++;
      if (num1 !== 16'h0000 || overflow1 !== 1'b0 || running1 !== 1'b0) begin
         errors++;
         $display("FAIL clear: num=%h ovf=%b run=%b expected 0000 0 0",
                  num1, overflow1, running1);
      end
      prev = running1;
      start1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 9) start1 = 1'b0;
         if (running1 !== prev) trans++;
         prev = running1;
      end
      checks++;
      if (trans != 1 || running1 !== 1'b1) begin
         errors++;
         $display("FAIL held_start: transitions=%0d run=%b expected 1 1", trans, running1);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      press_start1();
      wait_cyc(1);
      wait_cyc(10);
      start1 = 1'b1;
      lap1   = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lap1   = 1'b0;
      wait_cyc(1);
      checks++;
      if (running1 !== 1'b0 || lap_active1 !== 1'b0 || num1 !== 16'h0012) begin
         errors++;
         $display("FAIL simultaneous: run=%b lap=%b num=%h expected 0 0 0012",
                  running1, lap_active1, num1);
      end
      wait_cyc(3);
      checks++;
      if (num1 !== 16'h0012 || lap_active1 !== 1'b0) begin
         errors++;
         $display("FAIL simultaneous_hold: num=%h lap=%b expected 0012 0", num1, lap_active1);
      end
   endtask

   task automatic test_lap_stopped();
      do_reset();
      press_start1();
      wait_cyc(1);
      wait_cyc(19);
      press_lap1();
      wait_cyc(1);
      wait_cyc(4);
      press_start1();
      wait_cyc(1);
      checks++;
      if (running1 !== 1'b0 || lap_active1 !== 1'b1 || num1 !== 16'h0020) begin
         errors++;
         $display("FAIL lap_stopped: run=%b lap=%b num=%h expected 0 1 0020",
                  running1, lap_active1, num1);
      end
      wait_cyc(5);
      press_start1();
      wait_cyc(1);
      checks++;
      if (running1 !== 1'b1 || lap_active1 !== 1'b1 || num1 !== 16'h0020) begin
         errors++;
         $display("FAIL lap_resume: run=%b lap=%b num=%h expected 1 1 0020",
                  running1, lap_active1, num1);
      end
      wait_cyc(3);
      press_start1();
      wait_cyc(1);
      press_lap1();
      wait_cyc(1);
      checks++;
      if (running1 !== 1'b0 || lap_active1 !== 1'b0 || num1 !== 16'h0032) begin
         errors++;
         $display("FAIL lap_to_stopped: run=%b lap=%b num=%h expected 0 0 0032",
                  running1, lap_active1, num1);
      end
   endtask

   task automatic test_prescaler();
      press_start2();
      wait_cyc(1);
      wait_cyc(3);
      checks++;
      if (num2 !== 16'h0000 || running2 !== 1'b1) begin
         errors++;
         $display("FAIL div_before_tick: num=%h run=%b expected 0000 1", num2, running2);
      end
      wait_cyc(1);
      checks++;
      if (num2 !== 16'h0001) begin
         errors++;
         $display("FAIL div_first_tick: num=%h expected 0001", num2);
      end
      wait_cyc(36);
      checks++;
      if (num2 !== 16'h0010) begin
         errors++;
         $display("FAIL div_40_cycles: num=%h expected 0010", num2);
      end
      wait_cyc(1);
      press_start2();
      wait_cyc(1);
      wait_cyc(6);
      checks++;
      if (num2 !== 16'h0010 || running2 !== 1'b0) begin
         errors++;
         $display("FAIL div_stop: num=%h run=%b expected 0010 0", num2, running2);
      end
      press_start2();
      wait_cyc(1);
      wait_cyc(1);
      checks++;
      if (num2 !== 16'h0011) begin
         errors++;
         $display("FAIL div_fraction_kept: num=%h expected 0011", num2);
      end
      wait_cyc(4 * 8989);
      checks++;
      if (num2 !== 16'h9000 || overflow2 !== 1'b0 || lap_active2 !== 1'b0) begin
         errors++;
         $display("FAIL decimal_digit3: num=%h ovf=%b lap=%b expected 9000 0 0",
                  num2, overflow2, lap_active2);
      end
   endtask

   task automatic test_reset_mid_lap();
      do_reset();
      press_start1();
      wait_cyc(1);
      wait_cyc(249);
      press_lap1();
      wait_cyc(1);
      checks++;
      if (num1 !== 16'h0250 || lap_active1 !== 1'b1) begin
         errors++;
         $display("FAIL mid_lap_setup: num=%h lap=%b expected 0250 1", num1, lap_active1);
      end
      #2 clr = 1'b0;
      #1;
      checks++;
      if ({num1, running1, lap_active1, overflow1} !== 19'h0) begin
         errors++;
         $display("FAIL mid_lap_reset: num=%h run=%b lap=%b ovf=%b expected all 0",
                  num1, running1, lap_active1, overflow1);
      end
      @(negedge clk);
      clr = 1'b1;
      wait_cyc(2);
      press_start1();
      wait_cyc(1);
      wait_cyc(5);
      checks++;
      if (num1 !== 16'h0005 || running1 !== 1'b1 || lap_active1 !== 1'b0) begin
         errors++;
         $display("FAIL restart: num=%h run=%b lap=%b expected 0005 1 0",
                  num1, running1, lap_active1);
      end
   endtask

   initial begin
      test_reset();
      test_count_overflow();
      test_lap_hold();
      test_stop_clear();
      test_simultaneous();
      test_lap_stopped();
      test_prescaler();
      test_reset_mid_lap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
